// File: rtl/reg_dump_pkg.sv
// Types and helpers shared by the register dump reader and the trace consumer.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } dump_state_t;

    // The beat index needs one bit above the register address so it can name the jump register.
    function automatic int beat_idx_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Walks every register, plus the jump register if enabled, through the register file's
// combinational read port and streams each value out over a valid/ready port.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int W         = 8,
    parameter int A         = 2,
    parameter int INCL_JUMP = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic [W-1:0] RegData,
    input  logic [W-1:0] JumpRegIn,
    output logic [A-1:0] Raddr,
    output logic         Busy,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] OutData,
    output logic [A:0]   OutIndex,
    output logic         OutLast,
    output logic         Done
);

    localparam int IW = beat_idx_width(A);
    localparam logic [IW-1:0] JUMP_IDX = IW'(2**A);
    localparam logic [IW-1:0] LAST_IDX = (INCL_JUMP != 0) ? JUMP_IDX : IW'(2**A - 1);

    dump_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] idx_inc;
    logic [A-1:0]  raddr_q, raddr_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] index_q, index_d;
    logic          last_q, last_d;
    logic          done_q, done_d;

    assign idx_inc = idx_q + IW'(1);

    // Raddr is loaded on entry to FETCH, so the read data is valid during FETCH and held elsewhere.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raddr_d = raddr_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    raddr_d = '0;
                end
            end
            FETCH: begin
                if (Abort) begin
                    state_d = IDLE;
                end else begin
                    data_d  = (idx_q == JUMP_IDX) ? JumpRegIn : RegData;
                    index_d = idx_q;
                    last_d  = (idx_q == LAST_IDX);
                    state_d = SEND;
                end
            end
            SEND: begin
                // Abort takes priority over a handshake in the same cycle.
                if (Abort) begin
                    state_d = IDLE;
                end else if (OutReady) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_inc;
                        raddr_d = idx_inc[A-1:0];
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            raddr_q <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raddr_q <= raddr_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign Raddr    = raddr_q;
    assign Busy     = (state_q != IDLE);
    assign OutValid = (state_q == SEND);
    assign OutData  = data_q;
    assign OutIndex = index_q;
    assign OutLast  = last_q;
    assign Done     = done_q;

endmodule
